// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch unit: fetch PC, ROM req/ack handshake, decode hand-off, redirect flush, ack watchdog
module if_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] irom_inst,
  output logic [31:0] pc,
  output logic [31:0] npc_pc4,
  output logic        fetch_err
);

  localparam int WD_W = $clog2(ACK_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              valid_q, valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       npc_q, npc_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      fetch_pc_q <= RESET_PC;
      wd_cnt_q   <= '0;
      valid_q    <= 1'b0;
      inst_q     <= NOP_INST;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + 32'd4;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wd_cnt_q   <= wd_cnt_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wd_cnt_d   = wd_cnt_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    err_d      = err_q;

    if (redirect) begin
      // A same-cycle ack is for the old address and is dropped here.
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      valid_d    = 1'b0;
      inst_d     = NOP_INST;
      wd_cnt_d   = '0;
      err_d      = 1'b0;
      state_d    = S_REQ;
    end else begin
      unique case (state_q)
        S_RST: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            inst_d     = imem_rdata;
            pc_d       = fetch_pc_q;
            npc_d      = fetch_pc_q + 32'd4;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            wd_cnt_d   = '0;
            state_d    = S_FULL;
          end else if (wd_cnt_q == WD_LAST) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else if (wd_cnt_q != '1) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        S_FULL: begin
          if (!stall) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            state_d = S_REQ;
          end
        end
        S_ERR: state_d = S_ERR;
        default: state_d = S_RST;
      endcase
    end
  end

  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = valid_q;
  assign irom_inst  = inst_q;
  assign pc         = pc_q;
  assign npc_pc4    = npc_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed and randomized bench for if_fetch against a transaction-level model
module tb_if_fetch;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] SALT  = 32'hA5A5_0000;
  localparam int          TMO   = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, RESET_PC = 0
  logic        rst, ack_en, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack, inst_valid, fetch_err;
  logic [31:0] imem_addr, imem_rdata, irom_inst, pc, npc_pc4;

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = imem_addr ^ SALT;

  if_fetch #(.RESET_PC(32'h0), .ACK_TIMEOUT(TMO), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .irom_inst(irom_inst), .pc(pc), .npc_pc4(npc_pc4), .fetch_err(fetch_err)
  );

  // wrap instance, RESET_PC at the top of the address space
  logic        rst2, ack_en2, stall2, redirect2;
  logic [31:0] redirect_pc2;
  logic        imem_req2, imem_ack2, inst_valid2, fetch_err2;
  logic [31:0] imem_addr2, imem_rdata2, irom_inst2, pc2, npc_pc42;

  assign imem_ack2   = imem_req2 & ack_en2;
  assign imem_rdata2 = imem_addr2 ^ SALT;

  if_fetch #(.RESET_PC(32'hFFFF_FFFC), .ACK_TIMEOUT(TMO), .NOP_INST(NOP)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .stall(stall2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .inst_valid(inst_valid2),
    .irom_inst(irom_inst2), .pc(pc2), .npc_pc4(npc_pc42), .fetch_err(fetch_err2)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: what the fetch unit is doing, not how it encodes it.
  bit          m_boot, m_hold, m_err, m_valid;
  logic [31:0] m_next, m_inst, m_pc, m_npc;
  int          m_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit a, input bit s, input bit rd, input logic [31:0] rpc);
    bit requesting;
    requesting = !m_boot && !m_hold && !m_err;
    if (r) begin
      m_boot = 1; m_hold = 0; m_err = 0; m_valid = 0; m_wait = 0;
      m_next = 32'h0; m_inst = NOP; m_pc = 32'h0; m_npc = 32'h4;
    end else if (rd) begin
      m_next = {rpc[31:2], 2'b00};
      m_valid = 0; m_inst = NOP; m_wait = 0; m_err = 0; m_hold = 0; m_boot = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_hold) begin
      if (!s) begin m_hold = 0; m_valid = 0; m_inst = NOP; end
    end else if (requesting) begin
      if (a) begin
        m_inst = m_next ^ SALT; m_pc = m_next; m_npc = m_next + 32'd4;
        m_valid = 1; m_next = m_next + 32'd4; m_wait = 0; m_hold = 1;
      end else if (m_wait == TMO - 1) begin
        m_err = 1;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic step(input bit r, input bit a, input bit s, input bit rd, input logic [31:0] rpc);
    bit exp_req;
    rst = r; ack_en = a; stall = s; redirect = rd; redirect_pc = rpc;
    model_update(r, a, s, rd, rpc);
    @(posedge clk); #1;
    exp_req = !m_boot && !m_hold && !m_err;
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_next);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("irom_inst", irom_inst, m_inst);
    chk("pc", pc, m_pc);
    chk("npc_pc4", npc_pc4, m_npc);
    chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
  endtask

  task automatic step2(input bit r, input bit a, input bit s);
    rst2 = r; ack_en2 = a; stall2 = s;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; ack_en = 0; stall = 0; redirect = 0; redirect_pc = '0;
    rst2 = 1; ack_en2 = 0; stall2 = 0; redirect2 = 0; redirect_pc2 = '0;

    // Reset and boot
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_npc", npc_pc4, 32'h4);
    step(0, 1, 0, 0, 0);
    chk("boot_addr", imem_addr, 32'h0);
    step(0, 1, 0, 0, 0);
    chk("boot_inst0", irom_inst, 32'hA5A5_0000);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("boot_pc4", pc, 32'h4);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("boot_pc8", pc, 32'h8);

    // Stall hold
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    chk("stall_inst", irom_inst, 32'hA5A5_0008);
    chk("stall_valid", {31'b0, inst_valid}, 32'd1);
    step(0, 1, 0, 0, 0);
    chk("post_stall_addr", imem_addr, 32'hC);

    // Redirect colliding with an ack
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("pre_redir_addr", imem_addr, 32'h10);
    step(0, 1, 0, 1, 32'h0000_0103);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_inst", irom_inst, NOP);

    // Redirect over stall
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 32'h40);
    chk("redir_stall_addr", imem_addr, 32'h40);
    chk("redir_stall_req", {31'b0, imem_req}, 32'd1);

    // Watchdog
    for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 0, 0);
    chk("wd_not_yet", {31'b0, fetch_err}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("wd_err", {31'b0, fetch_err}, 32'd1);
    chk("wd_req", {31'b0, imem_req}, 32'd0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 32'h0);
    chk("wd_clear", {31'b0, fetch_err}, 32'd0);
    chk("wd_resume", imem_addr, 32'h0);

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | rpc[3:0];
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, rpc);
    end

    // Wrap and mid-run reset
    rst = 1;
    step2(1, 0, 0);
    step2(1, 0, 0);
    step2(0, 1, 0);
    chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    step2(0, 1, 0);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_npc", npc_pc42, 32'h0);
    step2(0, 1, 0);
    chk("wrap_next_addr", imem_addr2, 32'h0);
    step2(0, 1, 1);
    chk("wrap_pc0", pc2, 32'h0);
    step2(1, 1, 1);
    chk("midrst_valid", {31'b0, inst_valid2}, 32'd0);
    chk("midrst_pc", pc2, 32'hFFFF_FFFC);
    chk("midrst_inst", irom_inst2, NOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
